// File: rtl/memory_stage.sv
// Pipeline memory stage: E/M register, single-access load/store FSM over a ready bus, M/W register.
// Optional misaligned-access trap enabled by defining MEM_STAGE_ALIGN_CHECK_EN.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out_e,
  input  logic [31:0] write_data_e,
  input  logic [4:0]  write_reg_e,
  input  logic        reg_write_e,
  input  logic        mem_to_reg_e,
  input  logic        mem_write_e,
  input  logic        branch_e,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_m,
  output logic        branch_m,
  output logic [31:0] result_w,
  output logic [4:0]  write_reg_w,
  output logic        reg_write_w,
  output logic        addr_err_w
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] alu_out_m_q, alu_out_m_d;
  logic [31:0] write_data_m_q, write_data_m_d;
  logic [4:0]  write_reg_m_q, write_reg_m_d;
  logic        reg_write_m_q, reg_write_m_d;
  logic        mem_to_reg_m_q, mem_to_reg_m_d;
  logic        mem_write_m_q, mem_write_m_d;
  logic        branch_m_q, branch_m_d;
  logic [31:0] result_w_q, result_w_d;
  logic [4:0]  write_reg_w_q, write_reg_w_d;
  logic        reg_write_w_q, reg_write_w_d;
  logic        mem_op;
  logic        misaligned;
  logic        load_sel;

  assign mem_op = mem_write_m_q | mem_to_reg_m_q;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic addr_err_w_q, addr_err_w_d;

  assign misaligned   = mem_op & (alu_out_m_q[1:0] != 2'b00);
  assign addr_err_w_d = misaligned & ~stall_m;
  assign addr_err_w   = addr_err_w_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_err_w_q <= 1'b0;
    else     addr_err_w_q <= addr_err_w_d;
  end
`else
  assign misaligned = 1'b0;
  assign addr_err_w = 1'b0;
`endif

  // A store takes priority when both memory control bits are set.
  assign load_sel   = mem_to_reg_m_q & ~mem_write_m_q & ~misaligned;
  assign dmem_we    = mem_write_m_q;
  assign dmem_addr  = alu_out_m_q;
  assign dmem_wdata = write_data_m_q;
  assign branch_m   = branch_m_q;

  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    stall_m  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          dmem_req = 1'b1;
          if (!dmem_ready) begin
            stall_m = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        stall_m  = ~dmem_ready;
        if (dmem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_out_m_d    = alu_out_m_q;
    write_data_m_d = write_data_m_q;
    write_reg_m_d  = write_reg_m_q;
    reg_write_m_d  = reg_write_m_q;
    mem_to_reg_m_d = mem_to_reg_m_q;
    mem_write_m_d  = mem_write_m_q;
    branch_m_d     = branch_m_q;
    result_w_d     = result_w_q;
    write_reg_w_d  = write_reg_w_q;
    reg_write_w_d  = 1'b0;
    if (!stall_m) begin
      alu_out_m_d    = alu_out_e;
      write_data_m_d = write_data_e;
      write_reg_m_d  = write_reg_e;
      reg_write_m_d  = reg_write_e;
      mem_to_reg_m_d = mem_to_reg_e;
      mem_write_m_d  = mem_write_e;
      branch_m_d     = branch_e;
      result_w_d     = load_sel ? dmem_rdata : alu_out_m_q;
      write_reg_w_d  = write_reg_m_q;
      reg_write_w_d  = reg_write_m_q & ~misaligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      alu_out_m_q    <= '0;
      write_data_m_q <= '0;
      write_reg_m_q  <= '0;
      reg_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      mem_write_m_q  <= 1'b0;
      branch_m_q     <= 1'b0;
      result_w_q     <= '0;
      write_reg_w_q  <= '0;
      reg_write_w_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      alu_out_m_q    <= alu_out_m_d;
      write_data_m_q <= write_data_m_d;
      write_reg_m_q  <= write_reg_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_to_reg_m_q <= mem_to_reg_m_d;
      mem_write_m_q  <= mem_write_m_d;
      branch_m_q     <= branch_m_d;
      result_w_q     <= result_w_d;
      write_reg_w_q  <= write_reg_w_d;
      reg_write_w_q  <= reg_write_w_d;
    end
  end

  assign result_w    = result_w_q;
  assign write_reg_w = write_reg_w_q;
  assign reg_write_w = reg_write_w_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed scenarios plus random instructions and random memory wait states.
module tb_memory_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        mw;
    logic        br;
  } instr_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        err;
    logic        chk;
  } exp_t;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  localparam bit AlignCheck = 1'b1;
`else
  localparam bit AlignCheck = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out_e, write_data_e;
  logic [4:0]  write_reg_e;
  logic        reg_write_e, mem_to_reg_e, mem_write_e, branch_e;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        stall_m, branch_m;
  logic [31:0] result_w;
  logic [4:0]  write_reg_w;
  logic        reg_write_w, addr_err_w;

  int n_checks = 0;
  int n_passed = 0;

  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] resp_mem  [logic [31:0]];
  exp_t        sbq [$];

  memory_stage dut (
    .clk(clk), .rst(rst),
    .alu_out_e(alu_out_e), .write_data_e(write_data_e), .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_m(stall_m), .branch_m(branch_m),
    .result_w(result_w), .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
    .addr_err_w(addr_err_w)
  );

  always #5 clk = ~clk;

  // Contents of any never-written memory word, shared by the responder and the model.
  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] resp_read(input logic [31:0] a);
    if (resp_mem.exists(a)) return resp_mem[a];
    return mem_init(a);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return mem_init(a);
  endfunction

  function automatic bit is_mem(input instr_t i);
    return i.m2r || i.mw;
  endfunction

  function automatic bit is_misal(input instr_t i);
    return AlignCheck && is_mem(i) && (i.alu % 4 != 0);
  endfunction

  // Architectural effect of one instruction; memory ops execute in program order.
  function automatic exp_t outcome(input instr_t i);
    exp_t o;
    o.rd  = i.rd;
    o.chk = 1'b1;
    o.err = 1'b0;
    o.rw  = i.rw;
    o.result = i.alu;
    if (is_misal(i)) begin
      o.rw  = 1'b0;
      o.err = 1'b1;
      o.chk = 1'b0;
    end else if (i.mw) begin
      model_mem[i.alu] = i.wdata;
    end else if (i.m2r) begin
      o.result = model_read(i.alu);
    end
    return o;
  endfunction

  function automatic instr_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                                input logic rw, input logic m2r, input logic mw, input logic br);
    instr_t i;
    i.alu = a; i.wdata = wd; i.rd = rd; i.rw = rw; i.m2r = m2r; i.mw = mw; i.br = br;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int unsigned k, word, off;
    k    = $urandom_range(0, 3);
    word = $urandom_range(0, 15);
    off  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
    i.m2r   = (k == 1) || (k == 3);
    i.mw    = (k == 2) || (k == 3);
    i.alu   = (k == 0) ? $urandom : 32'h300 + 32'(word * 4 + off);
    i.wdata = $urandom;
    i.rd    = 5'($urandom);
    i.rw    = 1'($urandom);
    i.br    = 1'($urandom);
    return i;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input instr_t e, input logic rdy);
    @(posedge clk);
    #1;
    alu_out_e    = e.alu;
    write_data_e = e.wdata;
    write_reg_e  = e.rd;
    reg_write_e  = e.rw;
    mem_to_reg_e = e.m2r;
    mem_write_e  = e.mw;
    branch_e     = e.br;
    dmem_ready   = rdy;
    dmem_rdata   = rdy ? resp_read(dmem_addr) : $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, " dmem_req"}, 32'(dmem_req), 32'd0);
    checkOutput({tag, " stall_m"}, 32'(stall_m), 32'd0);
    checkOutput({tag, " branch_m"}, 32'(branch_m), 32'd0);
    checkOutput({tag, " result_w"}, result_w, 32'd0);
    checkOutput({tag, " write_reg_w"}, 32'(write_reg_w), 32'd0);
    checkOutput({tag, " reg_write_w"}, 32'(reg_write_w), 32'd0);
    checkOutput({tag, " addr_err_w"}, 32'(addr_err_w), 32'd0);
  endtask

  // Monitor: compares the memory bus against the instruction the model holds in M, and the
  // writeback outputs against the scoreboard after every edge that retires an instruction.
  instr_t m_cur = '0;
  exp_t   last_exp = '{result: 32'd0, rd: 5'd0, rw: 1'b0, err: 1'b0, chk: 1'b1};
  bit     w_pending = 1'b0;
  bit     prev_stall = 1'b0;
  int     stall_run = 0;

  always @(negedge clk) begin
    instr_t e;
    exp_t   x;
    bit     exp_req, stall_now;
    if (rst) begin
      sbq.delete();
      sbq.push_back('{result: 32'd0, rd: 5'd0, rw: 1'b0, err: 1'b0, chk: 1'b1});
      m_cur      = '0;
      last_exp   = '{result: 32'd0, rd: 5'd0, rw: 1'b0, err: 1'b0, chk: 1'b1};
      w_pending  = 1'b0;
      prev_stall = 1'b0;
      stall_run  = 0;
    end else begin
      if (w_pending) begin
        if (sbq.size() == 0) begin
          checkOutput("scoreboard empty", 32'd1, 32'd0);
        end else begin
          x = sbq.pop_front();
          if (x.chk) begin
            checkOutput("result_w", result_w, x.result);
            checkOutput("write_reg_w", 32'(write_reg_w), 32'(x.rd));
          end
          checkOutput("reg_write_w", 32'(reg_write_w), 32'(x.rw));
          checkOutput("addr_err_w", 32'(addr_err_w), 32'(x.err));
          last_exp = x;
        end
      end else if (prev_stall) begin
        checkOutput("bubble reg_write_w", 32'(reg_write_w), 32'd0);
        checkOutput("bubble addr_err_w", 32'(addr_err_w), 32'd0);
        if (last_exp.chk) begin
          checkOutput("bubble result_w hold", result_w, last_exp.result);
          checkOutput("bubble write_reg_w hold", 32'(write_reg_w), 32'(last_exp.rd));
        end
      end

      exp_req   = is_mem(m_cur) && !is_misal(m_cur);
      stall_now = exp_req && !dmem_ready;
      checkOutput("dmem_req", 32'(dmem_req), 32'(exp_req));
      checkOutput("stall_m", 32'(stall_m), 32'(stall_now));
      checkOutput("branch_m", 32'(branch_m), 32'(m_cur.br));
      if (exp_req) begin
        checkOutput("dmem_we", 32'(dmem_we), 32'(m_cur.mw));
        checkOutput("dmem_addr", dmem_addr, m_cur.alu);
        checkOutput("dmem_wdata", dmem_wdata, m_cur.wdata);
      end

      if (dmem_req && dmem_ready && dmem_we) resp_mem[dmem_addr] = dmem_wdata;

      stall_run = stall_now ? stall_run + 1 : 0;
      if (stall_run == 20) checkOutput("stall bound", 32'd1, 32'd0);

      if (!stall_now) begin
        e = '{alu_out_e, write_data_e, write_reg_e, reg_write_e, mem_to_reg_e, mem_write_e, branch_e};
        sbq.push_back(outcome(e));
        m_cur     = e;
        w_pending = 1'b1;
      end else begin
        w_pending = 1'b0;
      end
      prev_stall = stall_now;
    end
  end

  initial begin
    instr_t nop;
    int     zeros;
    logic   rdy;
    nop = '0;
    rst = 1'b1;
    {alu_out_e, write_data_e, write_reg_e, reg_write_e, mem_to_reg_e, mem_write_e, branch_e} = '0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    model_mem[32'h100] = 32'hDEADBEEF;
    resp_mem[32'h100]  = 32'hDEADBEEF;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    applyStimulus(mk(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1), 1'b1);
    applyStimulus(nop, 1'b1);
    applyStimulus(nop, 1'b1);

    applyStimulus(mk(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
    applyStimulus(nop, 1'b1);
    applyStimulus(nop, 1'b1);

    applyStimulus(mk(32'h200, 32'hCAFE0001, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
    applyStimulus(nop, 1'b0);
    applyStimulus(nop, 1'b0);
    applyStimulus(nop, 1'b0);
    applyStimulus(nop, 1'b1);
    applyStimulus(mk(32'h200, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
    applyStimulus(nop, 1'b1);

    applyStimulus(mk(32'h10, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
    applyStimulus(mk(32'h14, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
    applyStimulus(nop, 1'b1);
    applyStimulus(nop, 1'b1);

    applyStimulus(mk(32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
    applyStimulus(nop, 1'b1);
    applyStimulus(nop, 1'b1);

    applyStimulus(mk(32'h40, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1), 1'b1);
    applyStimulus(nop, 1'b0);
    applyStimulus(nop, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset mid-wait");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(nop, 1'b1);
    applyStimulus(mk(32'h44, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
    applyStimulus(nop, 1'b1);
    applyStimulus(nop, 1'b1);

    zeros = 0;
    repeat (400) begin
      rdy = (zeros >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
      zeros = rdy ? 0 : zeros + 1;
      applyStimulus(rand_instr(), rdy);
    end
    repeat (4) applyStimulus(nop, 1'b1);
    @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
